// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi BER checker.
package viterbi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } chk_state_e;

    // Bit positions inside err_o
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    localparam int CHK_DEPTH = 64;
    localparam int CHK_CNT_W = 16;

endpackage

// File: rtl/bit_fifo.sv
// 1-bit synchronous FIFO: circular buffer, wrapping pointers, occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module bit_fifo #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_q];
    // A push into a full buffer is only legal when a pop frees the slot.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Next-state for storage, pointers and occupancy; clr wins over traffic.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Register FIFO state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/viterbi_ber_checker.sv
// Receive-side scoreboard: buffers reference bits, pops one per decoded bit,
// and counts matches/mismatches over a fixed-length window.
module viterbi_ber_checker
    import viterbi_pkg::*;
#(
    parameter int DEPTH       = CHK_DEPTH,
    parameter int CNT_W       = CHK_CNT_W,
    parameter int COMPARE_LEN = 256,
    parameter int SKIP        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             ref_bit_i,
    input  logic             ref_vld_i,
    input  logic             dec_bit_i,
    input  logic             dec_vld_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] good_o,
    output logic [CNT_W-1:0] bad_o,
    output logic             first_bad_vld_o,
    output logic [CNT_W-1:0] first_bad_idx_o,
    output logic [1:0]       err_o
);
    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] skip_q, skip_d, cmp_q, cmp_d;
    logic [CNT_W-1:0] good_q, good_d, bad_q, bad_d, fbi_q, fbi_d;
    logic             fbv_q, fbv_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             push, pop, clr, full, empty, fifo_dout;

    bit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (ref_bit_i),
        .full  (full),
        .empty (empty),
        .dout  (fifo_dout)
    );

    // FSM next state, FIFO control and scoring. start_i restarts from any state.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        cmp_d   = cmp_q;
        good_d  = good_q;
        bad_d   = bad_q;
        fbv_d   = fbv_q;
        fbi_d   = fbi_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        if (start_i) begin
            state_d = RUN;
            skip_d  = CNT_W'(SKIP);
            cmp_d   = '0;
            good_d  = '0;
            bad_d   = '0;
            fbv_d   = 1'b0;
            fbi_d   = '0;
            err_d   = '0;
            clr     = 1'b1;
        end else if (state_q == RUN) begin
            if (cmp_q == CNT_W'(COMPARE_LEN)) begin
                // Window complete: stop taking traffic, report on this edge.
                state_d = DONE;
            end else if (dec_vld_i && empty) begin
                // No bypass: a same-cycle push cannot satisfy this pop.
                err_d[ERR_UNF] = 1'b1;
                state_d        = ERROR;
            end else if (ref_vld_i && full && !dec_vld_i) begin
                err_d[ERR_OVF] = 1'b1;
                state_d        = ERROR;
            end else begin
                push = ref_vld_i;
                pop  = dec_vld_i;
                if (dec_vld_i) begin
                    if (skip_q != '0) begin
                        skip_d = skip_q - 1'b1;
                    end else begin
                        cmp_d = cmp_q + 1'b1;
                        if (fifo_dout == dec_bit_i) begin
                            good_d = good_q + 1'b1;
                        end else begin
                            bad_d = bad_q + 1'b1;
                            if (!fbv_q) begin
                                fbv_d = 1'b1;
                                fbi_d = cmp_q;
                            end
                        end
                    end
                end
            end
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            skip_q  <= CNT_W'(SKIP);
            cmp_q   <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            fbv_q   <= 1'b0;
            fbi_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cmp_q   <= cmp_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            fbv_q   <= fbv_d;
            fbi_q   <= fbi_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign good_o          = good_q;
    assign bad_o           = bad_q;
    assign first_bad_vld_o = fbv_q;
    assign first_bad_idx_o = fbi_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench: three checker instances (default, SKIP=3, DEPTH=8) share
// stimulus; each test starts with start_i and checks only its target instance.
module tb_viterbi_ber_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0, ref_bit_i = 1'b0, ref_vld_i = 1'b0;
    logic dec_bit_i = 1'b0, dec_vld_i = 1'b0;

    logic        busy [3];
    logic        done [3];
    logic [15:0] good [3];
    logic [15:0] bad  [3];
    logic        fbv  [3];
    logic [15:0] fbi  [3];
    logic [1:0]  err  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    viterbi_ber_checker u_dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .ref_bit_i(ref_bit_i), .ref_vld_i(ref_vld_i),
        .dec_bit_i(dec_bit_i), .dec_vld_i(dec_vld_i),
        .busy_o(busy[0]), .done_o(done[0]), .good_o(good[0]), .bad_o(bad[0]),
        .first_bad_vld_o(fbv[0]), .first_bad_idx_o(fbi[0]), .err_o(err[0]));

    viterbi_ber_checker #(.SKIP(3)) u_skip (
        .clk(clk), .rst(rst), .start_i(start_i),
        .ref_bit_i(ref_bit_i), .ref_vld_i(ref_vld_i),
        .dec_bit_i(dec_bit_i), .dec_vld_i(dec_vld_i),
        .busy_o(busy[1]), .done_o(done[1]), .good_o(good[1]), .bad_o(bad[1]),
        .first_bad_vld_o(fbv[1]), .first_bad_idx_o(fbi[1]), .err_o(err[1]));

    viterbi_ber_checker #(.DEPTH(8)) u_small (
        .clk(clk), .rst(rst), .start_i(start_i),
        .ref_bit_i(ref_bit_i), .ref_vld_i(ref_vld_i),
        .dec_bit_i(dec_bit_i), .dec_vld_i(dec_vld_i),
        .busy_o(busy[2]), .done_o(done[2]), .good_o(good[2]), .bad_o(bad[2]),
        .first_bad_vld_o(fbv[2]), .first_bad_idx_o(fbi[2]), .err_o(err[2]));

    typedef struct {
        int delay;
        int sel;
        int inva;
        int invb;
        int exp_good;
        int exp_bad;
        int exp_fbv;
        int exp_fbi;
    } vec_t;

    vec_t vt [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle_in();
        start_i   = 1'b0;
        ref_vld_i = 1'b0;
        ref_bit_i = 1'b0;
        dec_vld_i = 1'b0;
        dec_bit_i = 1'b0;
    endtask

    // sel 0: 1,0,0,1,1,0,0,0,1,1,1,0 then all ones; sel 1: scrambled bits
    function automatic logic pat(input int i, input int sel);
        logic [11:0] p;
        p = 12'b1001_1000_1110;
        if (sel == 0) return (i < 12) ? p[11-i] : 1'b1;
        return i[0] ^ i[2] ^ i[5];
    endfunction

    task automatic pulse_start();
        idle_in();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Reference bit c pushed at cycle c; decoded bit k emitted at cycle k+delay.
    // The first g decoded bits are inverted garbage; scored bit j = k-g is
    // inverted when j equals inva or invb.
    task automatic run_stream(input int delay, input int g, input int total,
                              input int sel, input int inva, input int invb,
                              input int ncyc);
        int k;
        for (int c = 0; c < ncyc; c++) begin
            ref_vld_i = (c < total);
            ref_bit_i = (c < total) ? pat(c, sel) : 1'b0;
            k = c - delay;
            dec_vld_i = (k >= 0) && (k < total);
            dec_bit_i = 1'b0;
            if (dec_vld_i) begin
                if (k < g) dec_bit_i = ~pat(k, sel);
                else       dec_bit_i = pat(k, sel) ^ ((k - g == inva) || (k - g == invb));
            end
            tick();
        end
        idle_in();
    endtask

    // Called right after the edge carrying the last scored pop.
    task automatic end_check(input int inst, input string nm, input int eg,
                             input int eb, input int efv, input int efi);
        chk({nm, " busy@lastpop"}, int'(busy[inst]), 1);
        chk({nm, " done@lastpop"}, int'(done[inst]), 0);
        tick();
        chk({nm, " done"}, int'(done[inst]), 1);
        chk({nm, " busy@done"}, int'(busy[inst]), 0);
        // traffic while DONE must not move anything
        ref_vld_i = 1'b1; dec_vld_i = 1'b1; dec_bit_i = 1'b0;
        tick(); tick();
        idle_in();
        chk({nm, " good"}, int'(good[inst]), eg);
        chk({nm, " bad"}, int'(bad[inst]), eb);
        chk({nm, " fbv"}, int'(fbv[inst]), efv);
        if (efv != 0) chk({nm, " fbi"}, int'(fbi[inst]), efi);
        chk({nm, " err"}, int'(err[inst]), 0);
        chk({nm, " done held"}, int'(done[inst]), 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " busy"}, int'(busy[0]), 0);
        chk({nm, " done"}, int'(done[0]), 0);
        chk({nm, " good"}, int'(good[0]), 0);
        chk({nm, " bad"}, int'(bad[0]), 0);
        chk({nm, " fbv"}, int'(fbv[0]), 0);
        chk({nm, " fbi"}, int'(fbi[0]), 0);
        chk({nm, " err"}, int'(err[0]), 0);
    endtask

    initial begin
        vt[0] = '{5,  0, -1,  -1, 256, 0, 0, 0};
        vt[1] = '{5,  1, 17,  40, 254, 2, 1, 17};
        vt[2] = '{1,  1, 0,  255, 254, 2, 1, 0};
        vt[3] = '{8,  0, 255, -1, 255, 1, 1, 255};
        vt[4] = '{64, 1, 100, -1, 255, 1, 1, 100};

        // Reset state
        idle_in();
        rst = 1'b1;
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;
        // IDLE ignores traffic
        ref_vld_i = 1'b1; dec_vld_i = 1'b1;
        tick();
        idle_in();
        chk_zero("idle ignore");

        // Table-driven windows on the default instance
        for (int v = 0; v < 5; v++) begin
            pulse_start();
            chk($sformatf("vec%0d busy@start", v), int'(busy[0]), 1);
            run_stream(vt[v].delay, 0, 256, vt[v].sel, vt[v].inva, vt[v].invb,
                       256 + vt[v].delay);
            end_check(0, $sformatf("vec%0d", v), vt[v].exp_good, vt[v].exp_bad,
                      vt[v].exp_fbv, vt[v].exp_fbi);
        end

        // SKIP=3: three garbage pops discarded, 259 pops total
        pulse_start();
        run_stream(4, 3, 259, 1, -1, -1, 259 + 4);
        end_check(1, "skip", 256, 0, 0, 0);

        // DEPTH=8 overflow on the 9th push
        pulse_start();
        ref_vld_i = 1'b1; ref_bit_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("ovf before err", int'(err[2]), 0);
        chk("ovf before busy", int'(busy[2]), 1);
        tick();
        idle_in();
        chk("ovf err", int'(err[2]), 1);
        chk("ovf busy", int'(busy[2]), 0);
        chk("ovf done", int'(done[2]), 0);
        chk("ovf good", int'(good[2]), 0);
        chk("ovf bad", int'(bad[2]), 0);
        dec_vld_i = 1'b1;
        tick();
        idle_in();
        chk("ovf err held", int'(err[2]), 1);
        pulse_start();
        chk("ovf restart err", int'(err[2]), 0);
        chk("ovf restart busy", int'(busy[2]), 1);

        // Underflow on the first cycle after start, push in the same cycle
        pulse_start();
        ref_vld_i = 1'b1; ref_bit_i = 1'b1; dec_vld_i = 1'b1; dec_bit_i = 1'b1;
        tick();
        idle_in();
        chk("unf0 err", int'(err[0]), 2);
        chk("unf0 busy", int'(busy[0]), 0);
        chk("unf0 good", int'(good[0]), 0);
        chk("unf0 bad", int'(bad[0]), 0);

        // Underflow after scoring: counts keep their pre-error values
        pulse_start();
        ref_vld_i = 1'b1; ref_bit_i = 1'b1;
        tick();
        ref_bit_i = 1'b0; dec_vld_i = 1'b1; dec_bit_i = 1'b1;   // match
        tick();
        ref_vld_i = 1'b0; dec_bit_i = 1'b1;                     // popped 0: mismatch
        tick();
        ref_vld_i = 1'b1; dec_vld_i = 1'b1;                     // empty: underflow
        tick();
        idle_in();
        chk("unf1 err", int'(err[0]), 2);
        chk("unf1 good", int'(good[0]), 1);
        chk("unf1 bad", int'(bad[0]), 1);
        chk("unf1 fbv", int'(fbv[0]), 1);
        chk("unf1 fbi", int'(fbi[0]), 1);

        // rst at compare index 100, then a clean run
        pulse_start();
        run_stream(5, 0, 256, 0, -1, -1, 105);
        chk("midrst good", int'(good[0]), 100);
        chk("midrst busy", int'(busy[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");
        pulse_start();
        run_stream(5, 0, 256, 0, -1, -1, 261);
        end_check(0, "post-rst", 256, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Hardware scoreboard at the receive end of the conv-encode / Viterbi-decode chain.
- Captures each original bit presented to the encoder in a reference FIFO and pops one entry for each bit the decoder outputs, so the decoder's pipeline latency is absorbed automatically.
- Compares the popped bit with the decoded bit and keeps good/bad counts over a fixed-length window.
- Reports the index of the first mismatch plus overflow/underflow errors; used in error-injection runs and on silicon bring-up in place of a software checker.

Parameters:
DEPTH, 64, reference FIFO entries; power of 2, at least decoder latency + 2
CNT_W, 16, width of good/bad/index counters
COMPARE_LEN, 256, number of compared bits per run; must fit in CNT_W
SKIP, 0, leading decoded bits popped and discarded (traceback flush), not scored

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  one-cycle pulse; clears results, begins a run
ref_bit_i  in  1  original data bit (encoder_i)
ref_vld_i  in  1  ref_bit_i valid this cycle (enable_encoder_i)
dec_bit_i  in  1  decoder output bit (decoder_o)
dec_vld_i  in  1  dec_bit_i valid this cycle
busy_o  out  1  run in progress
done_o  out  1  COMPARE_LEN bits scored; held until start_i/rst
good_o  out  CNT_W  matching bits
bad_o  out  CNT_W  mismatching bits
first_bad_vld_o  out  1  at least one mismatch seen
first_bad_idx_o  out  CNT_W  compare index (0-based, after SKIP) of first mismatch
err_o  out  2  sticky: bit0 FIFO overflow, bit1 FIFO underflow

Behaviour:
- Reset (rst=1 at posedge clk):
  - State = IDLE; FIFO empty.
  - All outputs 0.
  - Counters 0; skip counter loaded with SKIP.
- States:
  - IDLE: ignores ref/dec inputs. start_i -> RUN; the FIFO and all results clear on the same edge.
  - RUN: busy_o=1.
    - Push ref_bit_i when ref_vld_i=1.
    - Pop when dec_vld_i=1.
    - When the compare index reaches COMPARE_LEN -> DONE.
    - An overflow or underflow -> ERROR.
  - DONE: done_o=1, busy_o=0. Inputs ignored; outputs frozen. start_i -> RUN with a fresh clear.
  - ERROR: busy_o=0, done_o=0, err_o held. Counts frozen at their pre-error values. start_i -> RUN with a clear (err_o cleared).
- FIFO: registered circular buffer with wrap-around pointers and an occupancy counter of clog2(DEPTH)+1 bits.
  - Push and pop in the same cycle when not empty: occupancy unchanged, both pointers advance.
  - Push when full with no pop: overflow. The push is dropped, err_o[0] is set, and the state goes to ERROR.
  - Push when full with a simultaneous pop: legal.
  - dec_vld_i=1 while occupancy==0: underflow, even if ref_vld_i=1 in the same cycle (no bypass path). err_o[1] is set, no count changes, and the state goes to ERROR.
- Scoring (one cycle latency: counters update on the edge at which the pop occurs):
  - While the skip counter is nonzero, a pop decrements it and nothing is scored.
  - Otherwise the popped bit is compared with dec_bit_i. Match: good_o+1. Mismatch: bad_o+1.
  - On the first mismatch, first_bad_idx_o is loaded with the current compare index and first_bad_vld_o is set to 1.
  - The compare index increments on every scored pop.
  - done_o asserts on the edge after the COMPARE_LEN-th scored pop.
- Invariant: good_o + bad_o == compare index. Counters cannot wrap because COMPARE_LEN < 2^CNT_W.
- start_i during RUN restarts the run: same clear as from IDLE.
- rst mid-run: returns to IDLE and discards FIFO contents.

Decomposition:
- viterbi_pkg:
  - chk_state_e enum: IDLE, RUN, DONE, ERROR.
  - ERR_OVF=0 and ERR_UNF=1 bit indices.
  - Default CHK_DEPTH/CHK_CNT_W constants.
- Sub-module bit_fifo: DEPTH-parameterised 1-bit synchronous FIFO with push, pop, clr, full, empty and dout. The checker owns the FSM and the counters.

Test Plan:
1. Encoder/decoder loopback via viterbi_tx_rx:
   - Stimulus: pattern 1,0,0,1,1,0,0,0,1,1,1,0... then all ones; SKIP=0, COMPARE_LEN=256.
   - Required: done_o=1, good_o=256, bad_o=0, first_bad_vld_o=0, err_o=0.
2. Direct drive, decoded stream a 5-cycle-delayed copy of the reference, with dec_bit_i inverted at compare indices 17 and 40.
   - Required: bad_o=2, good_o=254, first_bad_idx_o=17.
3. SKIP=3: decoder emits 3 garbage bits, then the aligned stream.
   - Required: garbage not scored; done_o after 259 pops; good_o=256.
4. DEPTH=8: 9 pushes with no pops.
   - Required: err_o=2'b01 on the 9th push; state ERROR; good_o=bad_o=0.
   - Then start_i: err_o clears, busy_o=1.
5. dec_vld_i and ref_vld_i both high on the first cycle after start_i (FIFO empty).
   - Required: err_o=2'b10, no count change.
6. rst asserted at compare index 100.
   - Required: all outputs 0 next edge, state IDLE.
   - Then start_i with a clean 256-bit run: good_o=256.
